vga_sync_receiver: RTL and testbench
====================================

// Module: vga_sync_receiver
// PURPOSE
//   Receiving end of the VGA timing interface: samples hsync/vsync/blank as driven
//   by the VGA controller, recovers active-pixel coordinates, measures line/frame
//   geometry and reports lock. Runs on the 25 MHz pixel clock. Used as an on-chip
//   loopback checker and as the front end for frame-capture logic.
// PARAMETERS
//   H_TOTAL     800  expected pixel clocks per line (hsync fall to hsync fall)
//   V_TOTAL     525  expected lines per frame (vsync fall to vsync fall)
//   H_ACTIVE    640  expected blank_n-high clocks per active line
//   V_ACTIVE    480  expected lines containing active pixels per frame
//   LOCK_FRAMES 2    consecutive good frames required to assert locked (1..15)
// PORTS
//   clk          in   1   pixel clock; one clock, every register on its rising edge
//   rst          in   1   synchronous active-high reset
//   hsync_n      in   1   horizontal sync, active low
//   vsync_n      in   1   vertical sync, active low
//   blank_n      in   1   high = active video pixel
//   pixel_valid  out  1   x/y describe the pixel sampled on the previous cycle
//   x            out  16  active-pixel column, 0..H_ACTIVE-1
//   y            out  16  active-pixel row, 0..V_ACTIVE-1
//   frame_start  out  1   one-cycle pulse, one cycle after each vsync falling edge
//   h_meas       out  16  last measured line length in clocks
//   v_meas       out  16  last measured frame length in lines
//   locked       out  1   geometry matched parameters for LOCK_FRAMES frames
//   err          out  1   one-cycle pulse on geometry mismatch while LOCKED
// BEHAVIOUR
//   - Reset: all outputs 0; hs_d/vs_d history regs 1; state SEARCH; counters 0.
//   - Edges: hs_fall = hs_d & ~hsync_n; vs_fall = vs_d & ~vsync_n (1 cycle detect).
//   - h_cnt: +1 per clk, saturates at 16'hFFFF; on hs_fall h_meas<=h_cnt+1, h_cnt<=0.
//   - line_cnt: +1 on hs_fall (saturating); on vs_fall v_meas<=line_cnt, line_cnt<=0.
//     If hs_fall and vs_fall coincide, the line increment counts before the capture.
//   - x_cnt: 0 on hs_fall; while blank_n=1: x<=x_cnt, y<=y_cnt, pixel_valid<=1,
//     x_cnt++. pixel_valid<=0 otherwise; x/y hold. Output latency exactly 1 clk.
//   - y_cnt: on hs_fall, +1 if the ending line had >=1 active pixel; 0 on vs_fall
//     (vs_fall wins over the increment). act_lines mirrors y_cnt for checking.
//   - Line good: at hs_fall, (h_cnt+1)==H_TOTAL and active count in {0,H_ACTIVE}.
//   - Frame good: at vs_fall, line_cnt(incl. coinciding hs_fall)==V_TOTAL,
//     act_lines==V_ACTIVE, and every line since the previous vs_fall was good.
//   - FSM:
//     SEARCH: locked=0; first vs_fall -> TRACK, good_frames=0 (partial frame ignored).
//     TRACK : at vs_fall: frame good -> good_frames++; reaching LOCK_FRAMES -> LOCKED;
//             frame bad -> good_frames=0, stay.
//     LOCKED: locked=1; bad line at hs_fall or bad frame at vs_fall -> err=1 for one
//             clk, locked<=0 same edge, -> TRACK with good_frames=0.
//     Any state: no hs_fall for 2*H_TOTAL clks -> SEARCH, locked=0 (no err pulse).
//   - frame_start pulses on every vs_fall regardless of state.
//   - rst mid-frame: everything returns to reset values next edge; re-lock needs a
//     vsync fall plus LOCK_FRAMES full good frames.
// TESTING
//   1 Nominal 640x480@800x525 from vga_controller, LOCK_FRAMES=2 -> locked rises at
//     3rd vsync fall; h_meas=800, v_meas=525; first pixel x=0,y=0; last x=639,y=479.
//   2 Count pixel_valid per frame -> exactly 307200; frame_start one pulse per frame.
//   3 While locked, stretch one line to 801 clks -> err 1-clk pulse at that hs_fall,
//     locked=0, h_meas=801; locked returns after 2 further good frames.
//   4 Hold hsync_n high 1600 clks -> state SEARCH, locked=0, err stays 0.
//   5 Frame with 479 active lines -> no lock progress; good_frames reset, v_meas=525.
//   6 Assert rst mid-line for 1 clk -> all outputs 0 next edge; recovery as in test 1.

Source files
------------

// File: rtl/vga_sync_receiver_if.sv
// VGA timing bundle between a sync source (master) and the sync receiver (slave):
// the three timing strobes plus everything the receiver recovers from them.
interface vga_sync_receiver_if;
  logic        hsync_n;
  logic        vsync_n;
  logic        blank_n;
  logic        pixel_valid;
  logic [15:0] x;
  logic [15:0] y;
  logic        frame_start;
  logic [15:0] h_meas;
  logic [15:0] v_meas;
  logic        locked;
  logic        err;

  modport master (
    output hsync_n, vsync_n, blank_n,
    input  pixel_valid, x, y, frame_start, h_meas, v_meas, locked, err
  );

  modport slave (
    input  hsync_n, vsync_n, blank_n,
    output pixel_valid, x, y, frame_start, h_meas, v_meas, locked, err
  );
endinterface

// File: rtl/vga_sync_receiver.sv
// Receiving end of the VGA timing interface: recovers active-pixel coordinates,
// measures line/frame geometry and tracks lock against the expected geometry.
module vga_sync_receiver #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic                clk,
  input  logic                rst,
  vga_sync_receiver_if.slave  vif
);

  localparam logic [15:0] H_TOTAL_W  = 16'(H_TOTAL);
  localparam logic [15:0] V_TOTAL_W  = 16'(V_TOTAL);
  localparam logic [15:0] H_ACTIVE_W = 16'(H_ACTIVE);
  localparam logic [15:0] V_ACTIVE_W = 16'(V_ACTIVE);
  localparam logic [15:0] TIMEOUT_W  = 16'(2 * H_TOTAL - 1);
  localparam logic [3:0]  LOCK_W     = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  good_frames_q, good_frames_d;
  logic        hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
  logic [15:0] h_cnt_q, h_cnt_d, line_cnt_q, line_cnt_d;
  logic [15:0] x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
  logic        lines_ok_q, lines_ok_d;
  logic        pixel_valid_q, pixel_valid_d, frame_start_q, frame_start_d;
  logic [15:0] x_q, x_d, y_q, y_d, h_meas_q, h_meas_d, v_meas_q, v_meas_d;
  logic        locked_q, locked_d, err_q, err_d;

  logic        hs_fall, vs_fall, line_good, line_bad, frame_good, timeout;
  logic [15:0] line_len, lines_now, act_now, x_base;
  logic        lines_ok_now;

  assign hs_fall = hs_prev_q & ~vif.hsync_n;
  assign vs_fall = vs_prev_q & ~vif.vsync_n;

  always_comb begin
    hs_prev_d     = vif.hsync_n;
    vs_prev_d     = vif.vsync_n;
    h_meas_d      = h_meas_q;
    v_meas_d      = v_meas_q;
    x_d           = x_q;
    y_d           = y_q;
    state_d       = state_q;
    good_frames_d = good_frames_q;
    err_d         = 1'b0;
    frame_start_d = vs_fall;
    pixel_valid_d = vif.blank_n;

    // A line is good with exactly H_TOTAL clocks and either no or a full row of pixels.
    line_len     = sat_inc(h_cnt_q);
    line_good    = (line_len == H_TOTAL_W) && ((x_cnt_q == 16'd0) || (x_cnt_q == H_ACTIVE_W));
    line_bad     = hs_fall && !line_good;
    lines_now    = hs_fall ? sat_inc(line_cnt_q) : line_cnt_q;
    act_now      = (hs_fall && (x_cnt_q != 16'd0)) ? sat_inc(y_cnt_q) : y_cnt_q;
    lines_ok_now = lines_ok_q && !line_bad;
    frame_good   = (lines_now == V_TOTAL_W) && (act_now == V_ACTIVE_W) && lines_ok_now;
    timeout      = !hs_fall && (h_cnt_q >= TIMEOUT_W);

    h_cnt_d    = hs_fall ? 16'd0 : sat_inc(h_cnt_q);
    line_cnt_d = vs_fall ? 16'd0 : lines_now;
    y_cnt_d    = vs_fall ? 16'd0 : act_now;
    lines_ok_d = vs_fall ? 1'b1 : lines_ok_now;
    if (hs_fall) h_meas_d = line_len;
    if (vs_fall) v_meas_d = lines_now;

    x_base  = hs_fall ? 16'd0 : x_cnt_q;
    x_cnt_d = x_base;
    if (vif.blank_n) begin
      x_d     = x_base;
      y_d     = y_cnt_q;
      x_cnt_d = sat_inc(x_base);
    end

    case (state_q)
      SEARCH: begin
        // The frame in progress when we start listening is partial, so it is skipped.
        if (vs_fall) begin
          state_d       = TRACK;
          good_frames_d = 4'd0;
        end
      end
      TRACK: begin
        if (vs_fall) begin
          if (frame_good) begin
            good_frames_d = good_frames_q + 4'd1;
            if (good_frames_q + 4'd1 >= LOCK_W) state_d = LOCKED;
          end else begin
            good_frames_d = 4'd0;
          end
        end
      end
      LOCKED: begin
        if (line_bad || (vs_fall && !frame_good)) begin
          err_d         = 1'b1;
          state_d       = TRACK;
          good_frames_d = 4'd0;
        end
      end
      default: state_d = SEARCH;
    endcase

    // Losing hsync altogether is a lost source, not a geometry error.
    if (timeout) begin
      state_d       = SEARCH;
      good_frames_d = 4'd0;
      err_d         = 1'b0;
    end
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= SEARCH;
      good_frames_q <= 4'd0;
      hs_prev_q     <= 1'b1;
      vs_prev_q     <= 1'b1;
      h_cnt_q       <= 16'd0;
      line_cnt_q    <= 16'd0;
      x_cnt_q       <= 16'd0;
      y_cnt_q       <= 16'd0;
      lines_ok_q    <= 1'b1;
      pixel_valid_q <= 1'b0;
      frame_start_q <= 1'b0;
      x_q           <= 16'd0;
      y_q           <= 16'd0;
      h_meas_q      <= 16'd0;
      v_meas_q      <= 16'd0;
      locked_q      <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      good_frames_q <= good_frames_d;
      hs_prev_q     <= hs_prev_d;
      vs_prev_q     <= vs_prev_d;
      h_cnt_q       <= h_cnt_d;
      line_cnt_q    <= line_cnt_d;
      x_cnt_q       <= x_cnt_d;
      y_cnt_q       <= y_cnt_d;
      lines_ok_q    <= lines_ok_d;
      pixel_valid_q <= pixel_valid_d;
      frame_start_q <= frame_start_d;
      x_q           <= x_d;
      y_q           <= y_d;
      h_meas_q      <= h_meas_d;
      v_meas_q      <= v_meas_d;
      locked_q      <= locked_d;
      err_q         <= err_d;
    end
  end

  assign vif.pixel_valid = pixel_valid_q;
  assign vif.x           = x_q;
  assign vif.y           = y_q;
  assign vif.frame_start = frame_start_q;
  assign vif.h_meas      = h_meas_q;
  assign vif.v_meas      = v_meas_q;
  assign vif.locked      = locked_q;
  assign vif.err         = err_q;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver on a reduced 32x16 in 48x24 raster so many
// frames fit in a short run; pixel coordinates are checked through a scoreboard.
module tb_vga_sync_receiver;
  localparam int HT = 48, HA = 32, HS0 = 36, HS1 = 44;
  localparam int VT = 24, VA = 16, VS0 = 18, VS1 = 20;

  typedef struct {int x; int y; bit chk;} px_t;

  logic clk = 1'b0;
  logic rst;
  vga_sync_receiver_if vif();

  vga_sync_receiver #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .vif(vif)
  );

  always #20 clk = ~clk;

  int  n_cmp = 0, n_bad = 0;
  px_t px_q[$];
  bit  obs_en = 0, rst_prev = 0, fs_exp = 0, vs_prev_drv = 1, locked_prev = 0, chk_en = 1;
  int  cur_v = -1, cur_h = -1, erow = 0, vf_cnt = 0, fs_seen = 0;
  int  pv_frame = 0, last_pv = 0;
  int  err_cnt = 0, err_v = -1, err_h = -1, err_hmeas = -1, err_locked = -1;
  int  lock_rises = 0, lock_vf = -1, lock_fs = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_cmp++;
    assert (obs === req) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, req);
    end
  endtask

  // One clock: observe what the last rising edge produced, then drive the next inputs.
  task automatic step(input bit hs, input bit vs, input bit bl, input bit r,
                      input int v, input int h);
    px_t e;
    @(negedge clk);
    if (obs_en) begin
      if (rst_prev) begin
        chk("rst_pixel_valid", 32'(vif.pixel_valid), 0);
        chk("rst_x",           32'(vif.x), 0);
        chk("rst_y",           32'(vif.y), 0);
        chk("rst_frame_start", 32'(vif.frame_start), 0);
        chk("rst_h_meas",      32'(vif.h_meas), 0);
        chk("rst_v_meas",      32'(vif.v_meas), 0);
        chk("rst_locked",      32'(vif.locked), 0);
        chk("rst_err",         32'(vif.err), 0);
      end
      if (px_q.size() > 0) begin
        e = px_q.pop_front();
        chk("pixel_valid", 32'(vif.pixel_valid), 1);
        if (e.chk) begin
          chk("pixel_x", 32'(vif.x), e.x);
          chk("pixel_y", 32'(vif.y), e.y);
        end
      end else begin
        chk("pixel_idle", 32'(vif.pixel_valid), 0);
      end
      chk("frame_start", 32'(vif.frame_start), 32'(fs_exp));
      if (vif.pixel_valid === 1'b1) pv_frame++;
      if (vif.frame_start === 1'b1) begin
        last_pv  = pv_frame;
        pv_frame = 0;
        fs_seen++;
      end
      if (vif.err === 1'b1) begin
        err_cnt++;
        err_v      = cur_v;
        err_h      = cur_h;
        err_hmeas  = int'(vif.h_meas);
        err_locked = int'(vif.locked);
      end
      if (vif.locked === 1'b1 && !locked_prev) begin
        lock_rises++;
        lock_vf = vf_cnt;
        lock_fs = int'(vif.frame_start);
      end
      locked_prev = (vif.locked === 1'b1);
    end
    vif.hsync_n = hs;
    vif.vsync_n = vs;
    vif.blank_n = bl;
    rst         = r;
    cur_v       = v;
    cur_h       = h;
    fs_exp      = !r && vs_prev_drv && !vs;
    if (fs_exp) vf_cnt++;
    vs_prev_drv = r ? 1'b1 : vs;
    rst_prev    = r;
    if (r) begin
      px_q.delete();
    end else if (bl) begin
      e.x = h; e.y = erow; e.chk = chk_en;
      px_q.push_back(e);
    end
  endtask

  task automatic line(input int v, input int len, input bit act, input int rst_h);
    for (int h = 0; h < len; h++) begin
      if (h == 0 && v == VS0) begin
        erow   = 0;
        chk_en = 1;
      end
      step(!(h >= HS0 && h < HS1), !(v >= VS0 && v < VS1), act && (h < HA),
           h == rst_h, v, h);
      if (h == rst_h) chk_en = 0;
    end
    if (act) erow++;
  endtask

  task automatic frame(input int stretch_v, input int blank_v, input int rst_v, input int rst_h);
    for (int v = 0; v < VT; v++)
      line(v, (v == stretch_v) ? HT + 1 : HT, (v < VA) && (v != blank_v),
           (v == rst_v) ? rst_h : -1);
  endtask

  initial begin
    rst = 1'b1;
    vif.hsync_n = 1'b1;
    vif.vsync_n = 1'b1;
    vif.blank_n = 1'b0;
    step(1, 1, 0, 1, -1, -1);
    step(1, 1, 0, 1, -1, -1);
    obs_en = 1;

    // Nominal raster: lock at the third vsync fall.
    for (int f = 0; f < 3; f++) frame(-1, -1, -1, -1);
    chk("lock_rises_nominal", lock_rises, 1);
    chk("lock_vsync_index", lock_vf, 3);
    chk("lock_with_frame_start", lock_fs, 1);
    chk("locked_nominal", 32'(vif.locked), 1);
    chk("h_meas_nominal", 32'(vif.h_meas), HT);
    chk("v_meas_nominal", 32'(vif.v_meas), VT);
    chk("pixels_per_frame", last_pv, HA * VA);

    // One stretched line while locked.
    frame(5, -1, -1, -1);
    chk("err_count_stretch", err_cnt, 1);
    chk("err_line", err_v, 6);
    chk("err_column", err_h, HS0);
    chk("err_h_meas", err_hmeas, HT + 1);
    chk("err_locked_same_edge", err_locked, 0);
    chk("locked_after_stretch", 32'(vif.locked), 0);
    for (int f = 0; f < 2; f++) frame(-1, -1, -1, -1);
    chk("lock_rises_relock", lock_rises, 2);
    chk("relock_vsync_index", lock_vf, 6);

    // hsync lost for longer than two lines.
    chk("locked_before_hold", 32'(vif.locked), 1);
    repeat (2 * HT + 4) step(1, 1, 0, 0, -2, 0);
    chk("locked_after_hold", 32'(vif.locked), 0);
    chk("err_count_hold", err_cnt, 1);
    for (int f = 0; f < 3; f++) frame(-1, -1, -1, -1);
    chk("lock_rises_after_hold", lock_rises, 3);
    chk("lock_vsync_after_hold", lock_vf, 9);

    // Reset mid-line, then a frame with one active line missing.
    frame(-1, -1, 3, 10);
    chk("locked_after_rst", 32'(vif.locked), 0);
    frame(-1, 5, -1, -1);
    chk("v_meas_short_frame", 32'(vif.v_meas), VT);
    chk("pixels_short_frame", last_pv, HA * (VA - 1));
    chk("locked_short_frame", 32'(vif.locked), 0);
    frame(-1, -1, -1, -1);
    chk("no_lock_progress", 32'(vif.locked), 0);
    frame(-1, -1, -1, -1);
    chk("lock_rises_final", lock_rises, 4);
    chk("lock_vsync_final", lock_vf, 13);
    chk("frame_start_pulses", fs_seen, vf_cnt);
    chk("err_count_final", err_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
